// File: rtl/iob_asym_fifo_ctrl.sv
// Asymmetric-width synchronous FIFO controller driving an external 2-port RAM.
// Define IOB_ASYM_FIFO_ERR_EN to add sticky w_overflow / r_underflow flags.
module iob_asym_fifo_ctrl #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 7,
  localparam int RATIO    = (W_DATA_W > R_DATA_W) ?
                            W_DATA_W / R_DATA_W :
                            R_DATA_W / W_DATA_W,
  localparam int LOG_R    = $clog2(RATIO),
  localparam int W_WIDE   = (W_DATA_W > R_DATA_W) ? 1 : 0,
  localparam int R_WIDE   = (R_DATA_W > W_DATA_W) ? 1 : 0,
  localparam int W_ADDR_W = W_WIDE ? ADDR_W - LOG_R : ADDR_W,
  localparam int R_ADDR_W = R_WIDE ? ADDR_W - LOG_R : ADDR_W,
  localparam int W_UNITS  = W_WIDE ? RATIO : 1,
  localparam int R_UNITS  = R_WIDE ? RATIO : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic [ADDR_W:0]     level,
  output logic                ext_mem_w_en,
  output logic [W_ADDR_W-1:0] ext_mem_w_addr,
  output logic [W_DATA_W-1:0] ext_mem_w_data,
  output logic                ext_mem_r_en,
  output logic [R_ADDR_W-1:0] ext_mem_r_addr,
  input  logic [R_DATA_W-1:0] ext_mem_r_data
`ifdef IOB_ASYM_FIFO_ERR_EN
  ,
  output logic                w_overflow,
  output logic                r_underflow
`endif
);

  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0] W_INC = LW'(W_UNITS);
  localparam logic [LW-1:0] R_DEC = LW'(R_UNITS);
  localparam logic [LW-1:0] FULL_TH =
    LW'((1 << ADDR_W) - W_UNITS);

  logic [W_ADDR_W-1:0] r_wptr;
  logic [R_ADDR_W-1:0] r_rptr;
  logic [LW-1:0]       r_level;
  logic                r_full;
  logic                r_empty_q;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [LW-1:0]       w_level_nxt;

  // rst_n gating keeps the RAM idle while reset is held
  assign w_wr_acc = w_en & ~r_full & ~clr & rst_n;
  assign w_rd_acc = r_en & ~r_empty_q & ~clr & rst_n;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_acc) w_level_nxt = w_level_nxt + W_INC;
    if (w_rd_acc) w_level_nxt = w_level_nxt - R_DEC;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_empty_q <= 1'b1;
    end else begin
      r_level   <= w_level_nxt;
      r_full    <= w_level_nxt > FULL_TH;
      r_empty_q <= w_level_nxt < R_DEC;
      if (w_wr_acc) r_wptr <= r_wptr + W_ADDR_W'(1);
      if (w_rd_acc) r_rptr <= r_rptr + R_ADDR_W'(1);
    end
  end

`ifdef IOB_ASYM_FIFO_ERR_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_en && r_full)    r_ovf <= 1'b1;
      if (r_en && r_empty_q) r_unf <= 1'b1;
    end
  end

  assign w_overflow  = r_ovf;
  assign r_underflow = r_unf;
`endif

  assign w_full         = r_full;
  assign r_empty        = r_empty_q;
  assign level          = r_level;
  assign r_data         = ext_mem_r_data;
  assign ext_mem_w_en   = w_wr_acc;
  assign ext_mem_w_addr = r_wptr;
  assign ext_mem_w_data = w_data;
  assign ext_mem_r_en   = w_rd_acc;
  assign ext_mem_r_addr = r_rptr;

endmodule

// File: doc/iob_asym_fifo_ctrl.md
# iob_asym_fifo_ctrl

Synchronous FIFO controller with asymmetric write/read widths. It sequences an external asymmetric two-port RAM (one write port, one read port, same clock) to provide a first-in first-out buffer. It owns the pointers, the occupancy count and the full/empty flags, and translates push/pop requests into RAM write/read strobes and addresses. It sits between a producer and a consumer of different word widths, for example a 32-bit bus feeding an 8-bit serializer.

## Interface
Parameters:
- W_DATA_W, 32, write word width.
- R_DATA_W, 8, read word width. The larger of W_DATA_W and R_DATA_W divided by the smaller (RATIO) is a power of 2, RATIO ≥ 1.
- ADDR_W, 7, address width of the narrower port. Capacity is 2^ADDR_W narrow words.
- Derived: W_ADDR_W and R_ADDR_W are ADDR_W on the narrow side and ADDR_W−log2(RATIO) on the wide side. W_UNITS and R_UNITS are the narrow words per write and per read (RATIO or 1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- clr  in  1  synchronous clear of pointers and level; has priority over w_en and r_en.
- w_en  in  1  push request.
- w_data  in  W_DATA_W  push data.
- w_full  out  1  high when one more write word does not fit.
- r_en  in  1  pop request.
- r_data  out  R_DATA_W  pop data, straight from the RAM read port.
- r_empty  out  1  high when less than one read word is stored.
- level  out  ADDR_W+1  occupancy in narrow words.
- ext_mem_w_en  out  1  RAM write strobe.
- ext_mem_w_addr  out  W_ADDR_W  RAM write address.
- ext_mem_w_data  out  W_DATA_W  RAM write data.
- ext_mem_r_en  out  1  RAM read strobe.
- ext_mem_r_addr  out  R_ADDR_W  RAM read address.
- ext_mem_r_data  in  R_DATA_W  RAM read data.

## Operation
- Accepted write: w_en & ~w_full & ~clr. Accepted read: r_en & ~r_empty & ~clr.
- An accepted write drives ext_mem_w_en=1, ext_mem_w_addr=wptr and ext_mem_w_data=w_data. wptr increments modulo 2^W_ADDR_W.
- An accepted read drives ext_mem_r_en=1 and ext_mem_r_addr=rptr. rptr increments modulo 2^R_ADDR_W.
- Memory strobes are combinational from the request and the registered flags. No RAM access occurs on a rejected request.
- level update: level_next = level + (accepted write ? W_UNITS : 0) − (accepted read ? R_UNITS : 0). Simultaneous accepted write and read apply both terms in the same cycle.
- w_full = (level > 2^ADDR_W − W_UNITS). r_empty = (level < R_UNITS). Both are registered and derived from level_next.
- Byte order is little-endian. The first narrow word pushed lands in the LSBs of the wide word read out. The LSB slice of a wide word pushed is the first narrow word popped.
- Write while full, or read while empty: ignored. Pointers, level and RAM are untouched, and r_data keeps its last value.
- Pointer wrap-around is natural binary wrap. level alone distinguishes full from empty.
- clr or reset: wptr=0, rptr=0, level=0, r_empty=1, w_full=0. RAM contents are not cleared.

## Timing
- Reset values: level=0, r_empty=1, w_full=0, ext_mem_w_en=0, ext_mem_r_en=0, ext_mem_w_addr=0, ext_mem_r_addr=0. r_data is undefined until the first read.
- The RAM write happens on the clk edge ending the accept cycle.
- Read latency is 1. r_data is valid the cycle after the accept and holds until the next accepted read.
- level, w_full and r_empty reflect an operation on the cycle after its accept edge.
- Write-to-read latency is 1: data pushed in cycle N can be accepted as a read in cycle N+1 once r_empty falls.
- Full-rate streaming: with RATIO=4 and wide writes, one write per 4 cycles sustains one read per cycle with no bubbles.
- Reset asserted mid-burst: the state is lost on that edge, and requests in the reset cycle are ignored.

## Configuration
- IOB_ASYM_FIFO_ERR_EN defined: adds two outputs, w_overflow and r_underflow (1 bit each).
  - Each is sticky, set the cycle after a rejected w_en or r_en respectively.
  - Both are cleared only by reset or clr.
- IOB_ASYM_FIFO_ERR_EN undefined: these ports and their logic do not exist. Rejected requests are silently dropped.

## Test plan
All scenarios use W_DATA_W=32, R_DATA_W=8, ADDR_W=4 (16 bytes).
- Reset: hold rst_n=0 for 3 cycles, then release. Required: level=0, r_empty=1, w_full=0, no memory strobes.
- Ordering: push 0x44332211, then pop 4 times. Required: r_data = 0x11, 0x22, 0x33, 0x44, each 1 cycle after its accepted r_en; level goes 4, 3, 2, 1, 0.
- Fill: push 4 words. Required: w_full=1 at level=16. A 5th push is ignored (no ext_mem_w_en). With the macro, w_overflow=1.
- Simultaneous: at level=4, assert w_en and r_en together. Required: level=7 the next cycle; pointers wrap correctly after 20 mixed operations; data matches the reference queue model.
- Empty read: pop on an empty FIFO. Required: no ext_mem_r_en, r_data unchanged; with the macro, r_underflow=1. clr then gives level=0 and r_underflow=0.
- Reverse ratio: W_DATA_W=8, R_DATA_W=32. Push 3 bytes: r_empty stays 1. Push a 4th byte: r_empty=0, and the pop returns the 4 bytes with the first byte in the LSBs.
